// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
package seq_pack;

    localparam int unsigned PC_W      = 10;
    localparam int unsigned SUB_IDX_W = 4;
    localparam int unsigned SKIP_W    = 3;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned IMEM_SIZE = 1024;
    localparam int unsigned RAS_DEPTH = 4;

    localparam logic [PC_W-1:0] SUB_BASE   = 10'd64;
    localparam logic [PC_W-1:0] SUB_STRIDE = 10'd16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } seq_state_t;

    // Entry point of subroutine idx; arithmetic is modulo the ROM depth.
    function automatic logic [PC_W-1:0] sub_entry(input logic [SUB_IDX_W-1:0] idx);
        return SUB_BASE + PC_W'(idx) * SUB_STRIDE;
    endfunction

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Hardware return-address stack (LIFO). Push/pop in the same cycle is illegal;
// push on full and pop on empty are ignored (the caller turns them into a fault).
module ret_stack
    import seq_pack::*;
#(
    parameter int unsigned DEPTH = RAS_DEPTH,
    parameter int unsigned W     = PC_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = IDX_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [LVL_W-1:0] lvl_q;
    logic [LVL_W-1:0] lvl_d;
    logic [LVL_W-1:0] top_lvl;

    // Status and top-of-stack view.
    always_comb begin
        top_lvl = lvl_q - LVL_W'(1);
        full    = (lvl_q == LVL_W'(DEPTH));
        empty   = (lvl_q == '0);
        dout    = mem_q[top_lvl[IDX_W-1:0]];
    end

    // Next stack contents and fill level.
    always_comb begin
        mem_d = mem_q;
        lvl_d = lvl_q;
        if (clear) begin
            lvl_d = '0;
        end else if (push && !full) begin
            mem_d[lvl_q[IDX_W-1:0]] = din;
            lvl_d                   = lvl_q + LVL_W'(1);
        end else if (pop && !empty) begin
            lvl_d = top_lvl;
        end
    end

    // Stack storage and level register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lvl_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            lvl_q <= lvl_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the 1024x9 instruction ROM: step, branch, skip,
// call/return via ret_stack, with a start/halt/fault state machine.
// Optional feature macro PC_SEQ_CYCLE_CNT_EN adds a saturating cycle_cnt output.
module pc_sequencer
    import seq_pack::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stall,
    input  logic                 halt,
    input  logic                 br_take,
    input  logic [PC_W-1:0]      br_target,
    input  logic                 skip_take,
    input  logic [SKIP_W-1:0]    skip_cnt,
    input  logic                 jsr,
    input  logic [SUB_IDX_W-1:0] jsr_idx,
    input  logic                 ret,
    output logic [PC_W-1:0]      pc,
    output logic                 running,
    output logic                 done,
    output logic                 ras_err
`ifdef PC_SEQ_CYCLE_CNT_EN
    ,
    output logic [CNT_W-1:0]     cycle_cnt
`endif
);

    seq_state_t      state_q;
    seq_state_t      state_d;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic            running_q;
    logic            running_d;
    logic            done_q;
    logic            done_d;
    logic            ras_err_q;
    logic            ras_err_d;

    logic            stk_push;
    logic            stk_pop;
    logic            stk_clear;
    logic [PC_W-1:0] stk_din;
    logic [PC_W-1:0] stk_dout;
    logic            stk_full;
    logic            stk_empty;

    logic            start_acc;
    logic            run_adv;
    logic [PC_W-1:0] pc_inc;

    ret_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ret_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (stk_push),
        .pop   (stk_pop),
        .clear (stk_clear),
        .din   (stk_din),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty)
    );

    // Next state, next pc and stack control; exactly one action per unstalled RUN cycle.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_clear = 1'b0;
        start_acc = 1'b0;
        run_adv   = 1'b0;
        pc_inc    = pc_q + PC_W'(1);
        stk_din   = pc_inc;

        if (!stall) begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d   = RUN;
                        pc_d      = '0;
                        stk_clear = 1'b1;
                        start_acc = 1'b1;
                    end
                end
                RUN: begin
                    if (halt) begin
                        state_d = DONE;
                    end else begin
                        run_adv = 1'b1;
                        if (ret) begin
                            if (stk_empty) begin
                                state_d = ERR;
                            end else begin
                                pc_d    = stk_dout;
                                stk_pop = 1'b1;
                            end
                        end else if (jsr) begin
                            if (stk_full) begin
                                state_d = ERR;
                            end else begin
                                pc_d     = sub_entry(jsr_idx);
                                stk_push = 1'b1;
                            end
                        end else if (br_take) begin
                            pc_d = br_target;
                        end else if (skip_take) begin
                            pc_d = pc_inc + PC_W'(skip_cnt);
                        end else begin
                            pc_d = pc_inc;
                        end
                    end
                end
                ERR: begin
                    // Only reset leaves the fault state.
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        running_d = (state_d == RUN);
        done_d    = (state_d == DONE);
        ras_err_d = ras_err_q | (state_d == ERR);
    end

    // State, pc and status registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            ras_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            running_q <= running_d;
            done_q    <= done_d;
            ras_err_q <= ras_err_d;
        end
    end

    assign pc      = pc_q;
    assign running = running_q;
    assign done    = done_q;
    assign ras_err = ras_err_q;

`ifdef PC_SEQ_CYCLE_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturating count of unstalled, non-halting RUN cycles; restarts on accepted start.
    always_comb begin
        cnt_d = cnt_q;
        if (start_acc) begin
            cnt_d = '0;
        end else if (run_adv && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Cycle counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cycle_cnt = cnt_q;
`else
    // Counter absent: the activity qualifiers have no consumer in this build.
    logic unused_cnt;
    assign unused_cnt = start_acc ^ run_adv;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by random
// strobes, all compared against a queue-based reference model.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stall;
    logic       halt;
    logic       br_take;
    logic [9:0] br_target;
    logic       skip_take;
    logic [2:0] skip_cnt;
    logic       jsr;
    logic [3:0] jsr_idx;
    logic       ret;
    logic [9:0] pc;
    logic       running;
    logic       done;
    logic       ras_err;
`ifdef PC_SEQ_CYCLE_CNT_EN
    logic [15:0] cycle_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_pc;
    bit m_run;
    bit m_done;
    bit m_err;
    int m_cnt;
    int m_stk[$];

    pc_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stall     (stall),
        .halt      (halt),
        .br_take   (br_take),
        .br_target (br_target),
        .skip_take (skip_take),
        .skip_cnt  (skip_cnt),
        .jsr       (jsr),
        .jsr_idx   (jsr_idx),
        .ret       (ret),
        .pc        (pc),
        .running   (running),
        .done      (done),
        .ras_err   (ras_err)
`ifdef PC_SEQ_CYCLE_CNT_EN
        ,
        .cycle_cnt (cycle_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        rst_n     = 1'b1;
        start     = 1'b0;
        stall     = 1'b0;
        halt      = 1'b0;
        br_take   = 1'b0;
        br_target = '0;
        skip_take = 1'b0;
        skip_cnt  = '0;
        jsr       = 1'b0;
        jsr_idx   = '0;
        ret       = 1'b0;
    endtask

    task automatic model_fault();
        m_run = 1'b0;
        m_err = 1'b1;
    endtask

    // Advance the model by one clock using the current inputs, clock the DUT, compare.
    task automatic tick(input string tag);
        if (!rst_n) begin
            m_pc = 0; m_run = 0; m_done = 0; m_err = 0; m_cnt = 0;
            m_stk.delete();
        end else if (!stall) begin
            if (!m_run && !m_err) begin
                if (start) begin
                    m_run = 1; m_done = 0; m_pc = 0; m_cnt = 0;
                    m_stk.delete();
                end
            end else if (m_run) begin
                if (halt) begin
                    m_run  = 0;
                    m_done = 1;
                end else begin
                    if (m_cnt < 65535) m_cnt++;
                    if (ret) begin
                        if (m_stk.size() == 0) model_fault();
                        else m_pc = m_stk.pop_back();
                    end else if (jsr) begin
                        if (m_stk.size() == 4) model_fault();
                        else begin
                            m_stk.push_back((m_pc + 1) % 1024);
                            m_pc = 64 + int'(jsr_idx) * 16;
                        end
                    end else if (br_take) begin
                        m_pc = int'(br_target);
                    end else if (skip_take) begin
                        m_pc = (m_pc + 1 + int'(skip_cnt)) % 1024;
                    end else begin
                        m_pc = (m_pc + 1) % 1024;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        chk({tag, ".pc"}, 32'(pc), 32'(m_pc));
        chk({tag, ".running"}, 32'(running), 32'(m_run));
        chk({tag, ".done"}, 32'(done), 32'(m_done));
        chk({tag, ".ras_err"}, 32'(ras_err), 32'(m_err));
`ifdef PC_SEQ_CYCLE_CNT_EN
        chk({tag, ".cycle_cnt"}, 32'(cycle_cnt), 32'(m_cnt));
`endif
    endtask

    initial begin
        int exp_ret[4];
        exp_ret = '{97, 81, 65, 12};
        m_pc = 0; m_run = 0; m_done = 0; m_err = 0; m_cnt = 0;

        // T1: reset then free run
        clr_in();
        rst_n = 1'b0;
        tick("T1.rst0");
        tick("T1.rst1");
        chk("T1.pc_rst", 32'(pc), 0);
        chk("T1.running_rst", 32'(running), 0);
        chk("T1.done_rst", 32'(done), 0);
        chk("T1.ras_err_rst", 32'(ras_err), 0);
        rst_n = 1'b1;
        start = 1'b1;
        tick("T1.start");
        start = 1'b0;
        repeat (5) tick("T1.step");
        chk("T1.pc5", 32'(pc), 5);

        // T2: call/return and 4-deep nesting
        repeat (5) tick("T2.step");
        chk("T2.pc10", 32'(pc), 10);
        jsr = 1'b1; jsr_idx = 4'd2;
        tick("T2.jsr");
        jsr = 1'b0;
        chk("T2.pc96", 32'(pc), 96);
        ret = 1'b1;
        tick("T2.ret");
        ret = 1'b0;
        chk("T2.pc11", 32'(pc), 11);
        for (int i = 0; i < 4; i++) begin
            jsr = 1'b1; jsr_idx = 4'(i);
            tick("T2.nest");
        end
        jsr = 1'b0;
        chk("T2.pc112", 32'(pc), 112);
        for (int i = 0; i < 4; i++) begin
            ret = 1'b1;
            tick("T2.unnest");
            chk("T2.ret_order", 32'(pc), 32'(exp_ret[i]));
        end
        ret = 1'b0;

        // T3: overflow, sticky error, underflow
        for (int i = 0; i < 5; i++) begin
            jsr = 1'b1; jsr_idx = 4'd0;
            tick("T3.jsr");
        end
        jsr = 1'b0;
        chk("T3.ovf_pc", 32'(pc), 64);
        chk("T3.ovf_err", 32'(ras_err), 1);
        chk("T3.ovf_run", 32'(running), 0);
        start = 1'b1;
        tick("T3.start_ign");
        start = 1'b0;
        chk("T3.start_ign_run", 32'(running), 0);
        rst_n = 1'b0;
        tick("T3.rst");
        rst_n = 1'b1;
        chk("T3.err_clr", 32'(ras_err), 0);
        start = 1'b1;
        tick("T3.start");
        start = 1'b0;
        ret = 1'b1;
        tick("T3.unf");
        ret = 1'b0;
        chk("T3.unf_err", 32'(ras_err), 1);
        chk("T3.unf_pc", 32'(pc), 0);

        // T4: priority and skip wrap
        rst_n = 1'b0;
        tick("T4.rst");
        rst_n = 1'b1;
        start = 1'b1;
        tick("T4.start");
        start = 1'b0;
        repeat (20) tick("T4.step");
        br_take = 1'b1; br_target = 10'd300; skip_take = 1'b1; skip_cnt = 3'd2;
        tick("T4.prio");
        skip_take = 1'b0;
        chk("T4.pc300", 32'(pc), 300);
        br_target = 10'd1022;
        tick("T4.br1022");
        br_take = 1'b0;
        skip_take = 1'b1; skip_cnt = 3'd3;
        tick("T4.skipwrap");
        skip_take = 1'b0;
        chk("T4.pc2", 32'(pc), 2);

        // T5: stall then halt and restart
        stall = 1'b1; br_take = 1'b1; br_target = 10'd500;
        repeat (3) begin
            tick("T5.stall");
            chk("T5.stall_pc", 32'(pc), 2);
        end
        stall = 1'b0; br_take = 1'b0;
        halt = 1'b1;
        tick("T5.halt");
        halt = 1'b0;
        chk("T5.done", 32'(done), 1);
        tick("T5.frozen");
        chk("T5.frozen_pc", 32'(pc), 2);
        start = 1'b1;
        tick("T5.restart");
        start = 1'b0;
        chk("T5.restart_pc", 32'(pc), 0);
        chk("T5.restart_run", 32'(running), 1);

`ifdef PC_SEQ_CYCLE_CNT_EN
        // T6: cycle counter with stalls
        rst_n = 1'b0;
        tick("T6.rst");
        rst_n = 1'b1;
        start = 1'b1;
        tick("T6.start");
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            stall = (i == 2 || i == 5);
            tick("T6.run");
        end
        stall = 1'b0;
        halt = 1'b1;
        tick("T6.halt");
        halt = 1'b0;
        chk("T6.cnt5", 32'(cycle_cnt), 5);
        tick("T6.hold");
        chk("T6.cnt_hold", 32'(cycle_cnt), 5);
`endif

        // Random strobes against the model
        for (int n = 0; n < 3000; n++) begin
            rst_n     = ($urandom_range(0, 299) != 0);
            stall     = ($urandom_range(0, 5) == 0);
            start     = ($urandom_range(0, 3) == 0);
            halt      = ($urandom_range(0, 39) == 0);
            ret       = ($urandom_range(0, 5) == 0);
            jsr       = ($urandom_range(0, 5) == 0);
            jsr_idx   = 4'($urandom);
            br_take   = ($urandom_range(0, 7) == 0);
            br_target = 10'($urandom);
            skip_take = ($urandom_range(0, 3) == 0);
            skip_cnt  = 3'($urandom);
            tick("RND");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
